// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT stage controllers: width helper and the
// common four-state frame FSM encoding.
package fft_ctrl_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN1 = 2'd1,
        DRAIN2 = 2'd2,
        UPDATE = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/sat_clip.sv
// Symmetric saturation of a signed word to W_OUT bits; also reports whether
// the input was clipped and whether it used the top output bit (big).
module sat_clip #(
    parameter int W_IN  = 11,
    parameter int W_OUT = 8
) (
    input  logic signed [W_IN-1:0]  y_in,
    output logic signed [W_OUT-1:0] y_out,
    output logic                    clip,
    output logic                    big
);

    localparam logic signed [W_IN-1:0] POS_LIM = W_IN'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [W_IN-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [W_IN-1:0] BIG_POS = W_IN'(2 ** (W_OUT - 2));
    localparam logic signed [W_IN-1:0] BIG_NEG = -BIG_POS;

    // The most negative output code is never produced, keeping the range symmetric.
    always_comb begin
        y_out = y_in[W_OUT-1:0];
        clip  = 1'b0;
        if (y_in > POS_LIM) begin
            y_out = POS_LIM[W_OUT-1:0];
            clip  = 1'b1;
        end else if (y_in < NEG_LIM) begin
            y_out = NEG_LIM[W_OUT-1:0];
            clip  = 1'b1;
        end
        big = (y_in >= BIG_POS) || (y_in <= BIG_NEG);
    end

endmodule

// File: rtl/clip_scale_ctrl.sv
// Frame-adaptive rounding shifter and saturator between FFT stages. The shift
// is re-evaluated at each N-sample frame boundary from that frame's clip stats.
module clip_scale_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int IL      = 10,
    parameter int OL      = 8,
    parameter int N       = 64,
    parameter int SMAX    = 3,
    parameter int SINIT   = 0,
    parameter int CLIP_TH = 0
) (
    input  logic                        iCLK,
    input  logic                        iRSTn,
    input  logic                        iCLR,
    input  logic                        iVALID,
    input  logic [IL-1:0]               iDATA,
    output logic                        oREADY,
    output logic                        oVALID,
    output logic [OL-1:0]               oDATA,
    output logic                        oEOF,
    output logic [clog2(N+1)-1:0]       oCLIP_CNT,
    output logic [clog2(SMAX+1)-1:0]    oSHIFT,
    output logic [1:0]                  oSTATE
);

    localparam int CW = clog2(N + 1);
    localparam int SW = clog2(SMAX + 1);
    localparam int FW = clog2(N);
    localparam logic [FW-1:0] LAST_IDX   = FW'(N - 1);
    localparam logic [SW-1:0] SHIFT_MAX  = SW'(SMAX);
    localparam logic [SW-1:0] SHIFT_INIT = SW'(SINIT);

    ctrl_state_e          state_q, state_d;
    logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [SW-1:0]        shift_q, shift_d;
    logic                 in_valid_q, in_valid_d;
    logic [IL-1:0]        in_data_q, in_data_d;
    logic                 s1_valid_q, s1_valid_d;
    logic signed [IL:0]   s1_y_q, s1_y_d;
    logic                 out_valid_q, out_valid_d;
    logic [OL-1:0]        out_data_q, out_data_d;
    logic [CW-1:0]        clip_cnt_q, clip_cnt_d;
    logic                 big_q, big_d;
    logic                 eof_q, eof_d;
    logic [CW-1:0]        clip_last_q, clip_last_d;

    logic                 accept;
    logic signed [IL:0]   x_ext;
    logic signed [IL:0]   rnd;
    logic signed [IL:0]   y_rnd;
    logic signed [OL-1:0] sat_y;
    logic                 sat_clip_flag;
    logic                 sat_big;

    assign oREADY    = (state_q == RUN);
    assign accept    = iVALID && oREADY;
    assign oVALID    = out_valid_q;
    assign oDATA     = out_data_q;
    assign oEOF      = eof_q;
    assign oCLIP_CNT = clip_last_q;
    assign oSHIFT    = shift_q;
    assign oSTATE    = state_q;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        x_ext = {in_data_q[IL-1], in_data_q};
        rnd   = '0;
        if (shift_q != '0) begin
            rnd = (IL+1)'(1) << (shift_q - SW'(1));
        end
        y_rnd = (x_ext + rnd) >>> shift_q;
    end

    sat_clip #(
        .W_IN  (IL + 1),
        .W_OUT (OL)
    ) u_sat_clip (
        .y_in  (s1_y_q),
        .y_out (sat_y),
        .clip  (sat_clip_flag),
        .big   (sat_big)
    );

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        shift_d     = shift_q;
        in_valid_d  = accept;
        in_data_d   = accept ? iDATA : in_data_q;
        s1_valid_d  = in_valid_q;
        s1_y_d      = in_valid_q ? y_rnd : s1_y_q;
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? sat_y : out_data_q;
        clip_cnt_d  = clip_cnt_q;
        big_d       = big_q;
        eof_d       = 1'b0;
        clip_last_d = clip_last_q;

        if (s1_valid_q) begin
            clip_cnt_d = clip_cnt_q + {{(CW-1){1'b0}}, sat_clip_flag};
            big_d      = big_q | sat_big;
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (frame_cnt_q == LAST_IDX) begin
                        frame_cnt_d = '0;
                        state_d     = DRAIN1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: state_d = UPDATE;
            UPDATE: begin
                // Pipeline is empty here, so clip_cnt_q/big_q are the whole frame.
                state_d     = RUN;
                eof_d       = 1'b1;
                clip_last_d = clip_cnt_q;
                clip_cnt_d  = '0;
                big_d       = 1'b0;
                if ((int'(clip_cnt_q) > CLIP_TH) && (shift_q < SHIFT_MAX)) begin
                    shift_d = shift_q + SW'(1);
                end else if ((clip_cnt_q == '0) && !big_q && (shift_q != '0)) begin
                    shift_d = shift_q - SW'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (iCLR) begin
            state_d     = RUN;
            frame_cnt_d = '0;
            shift_d     = SHIFT_INIT;
            in_valid_d  = 1'b0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            clip_cnt_d  = '0;
            big_d       = 1'b0;
            eof_d       = 1'b0;
            clip_last_d = clip_last_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q     <= RUN;
            frame_cnt_q <= '0;
            shift_q     <= SHIFT_INIT;
            in_valid_q  <= 1'b0;
            in_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_y_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            clip_cnt_q  <= '0;
            big_q       <= 1'b0;
            eof_q       <= 1'b0;
            clip_last_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            shift_q     <= shift_d;
            in_valid_q  <= in_valid_d;
            in_data_q   <= in_data_d;
            s1_valid_q  <= s1_valid_d;
            s1_y_q      <= s1_y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            clip_cnt_q  <= clip_cnt_d;
            big_q       <= big_d;
            eof_q       <= eof_d;
            clip_last_q <= clip_last_d;
        end
    end

endmodule

// File: tb/tb_clip_scale_ctrl.sv
// Bench for clip_scale_ctrl: directed frame table, clear and reset sequences,
// then random frames checked against an arithmetic reference model.
module tb_clip_scale_ctrl;

    localparam int IL      = 10;
    localparam int OL      = 8;
    localparam int N       = 4;
    localparam int SMAX    = 3;
    localparam int SINIT   = 0;
    localparam int CLIP_TH = 0;

    logic          iCLK = 1'b0;
    logic          iRSTn = 1'b0;
    logic          iCLR = 1'b0;
    logic          iVALID = 1'b0;
    logic [IL-1:0] iDATA = '0;
    logic          oREADY;
    logic          oVALID;
    logic [OL-1:0] oDATA;
    logic          oEOF;
    logic [2:0]    oCLIP_CNT;
    logic [1:0]    oSHIFT;
    logic [1:0]    oSTATE;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int din[N];
        int dout[N];
        int clip;
        int shift;
    } frame_vec_t;

    typedef struct {
        int data;
        int cyc;
    } out_exp_t;

    typedef struct {
        int clip;
        int shift;
        int cyc;
    } eof_exp_t;

    frame_vec_t tbl[10];
    frame_vec_t cur;
    out_exp_t   exp_q[$];
    eof_exp_t   eof_q[$];

    int m_shift;
    int m_clip_total;
    int m_big;

    clip_scale_ctrl #(
        .IL(IL), .OL(OL), .N(N), .SMAX(SMAX), .SINIT(SINIT), .CLIP_TH(CLIP_TH)
    ) dut (
        .iCLK      (iCLK),
        .iRSTn     (iRSTn),
        .iCLR      (iCLR),
        .iVALID    (iVALID),
        .iDATA     (iDATA),
        .oREADY    (oREADY),
        .oVALID    (oVALID),
        .oDATA     (oDATA),
        .oEOF      (oEOF),
        .oCLIP_CNT (oCLIP_CNT),
        .oSHIFT    (oSHIFT),
        .oSTATE    (oSTATE)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge iCLK) begin
        out_exp_t oe;
        eof_exp_t ee;
        if (iRSTn) begin
            if (oVALID) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0d, required no output (cycle %0d)",
                             $signed(oDATA), cyc);
                end else begin
                    oe = exp_q.pop_front();
                    check("out_data", int'($signed(oDATA)), oe.data);
                    check("out_cycle", cyc, oe.cyc);
                end
            end
            if (oEOF) begin
                if (eof_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_eof: got oEOF=1, required 0 (cycle %0d)", cyc);
                end else begin
                    ee = eof_q.pop_front();
                    check("eof_clip_cnt", int'(oCLIP_CNT), ee.clip);
                    check("eof_shift", int'(oSHIFT), ee.shift);
                    check("eof_cycle", cyc, ee.cyc);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int scale(input int x, input int s);
        int d;
        int t;
        d = 1 << s;
        t = x + d / 2;
        return (t >= 0) ? t / d : -((-t + d - 1) / d);
    endfunction

    task automatic model_frame(input int x0, input int x1, input int x2, input int x3);
        int y;
        int xs[N];
        int lim;
        lim = (1 << (OL - 1)) - 1;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        m_clip_total = 0;
        m_big = 0;
        for (int k = 0; k < N; k++) begin
            cur.din[k] = xs[k];
            y = scale(xs[k], m_shift);
            if (((y < 0) ? -y : y) >= (1 << (OL - 2))) m_big = 1;
            if (y > lim) begin
                cur.dout[k] = lim;
                m_clip_total++;
            end else if (y < -lim) begin
                cur.dout[k] = -lim;
                m_clip_total++;
            end else begin
                cur.dout[k] = y;
            end
        end
        if (m_clip_total > CLIP_TH && m_shift < SMAX) m_shift++;
        else if (m_clip_total == 0 && m_big == 0 && m_shift > 0) m_shift--;
        cur.clip = m_clip_total;
        cur.shift = m_shift;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int x, input int e, output int acc, output int waited);
        waited = 0;
        iVALID = 1'b1;
        iDATA  = IL'(x);
        while (!oREADY && waited < 16) begin
            @(posedge iCLK);
            #1;
            waited++;
        end
        if (!oREADY) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got oREADY=0, required 1 (cycle %0d)", cyc);
            acc = -1;
            iVALID = 1'b0;
        end else begin
            acc = cyc + 1;
            exp_q.push_back(out_exp_t'{data: e, cyc: acc + 2});
            @(posedge iCLK);
            #1;
            iVALID = 1'b0;
        end
    endtask

    task automatic drive_frame(input int gap_max, input bit chk_wait);
        int acc;
        int waited;
        int g;
        acc = -1;
        for (int k = 0; k < N; k++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                @(posedge iCLK);
                #1;
            end
            send(cur.din[k], cur.dout[k], acc, waited);
            if (k == 0 && chk_wait) check("ready_low_cycles", waited, 3);
        end
        if (acc >= 0) eof_q.push_back(eof_exp_t'{clip: cur.clip, shift: cur.shift, cyc: acc + 3});
    endtask

    task automatic set_row(input int i,
                           input int d0, input int d1, input int d2, input int d3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int c, input int s);
        tbl[i].din[0] = d0; tbl[i].din[1] = d1; tbl[i].din[2] = d2; tbl[i].din[3] = d3;
        tbl[i].dout[0] = e0; tbl[i].dout[1] = e1; tbl[i].dout[2] = e2; tbl[i].dout[3] = e3;
        tbl[i].clip = c;
        tbl[i].shift = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int w;
        int xs[N];
        int amp;
        int mode;

        // Hand-computed frames; shift listed is the value after the frame.
        set_row(0,    5,   -7,  127, -127,    5,   -7,  127, -127, 0, 0);
        set_row(1,  300, -512,   10, -128,  127, -127,   10, -127, 3, 1);
        set_row(2,    3,   -3,  300, -512,    2,   -1,  127, -127, 2, 2);
        set_row(3,  300, -512,    0,    0,   75, -127,    0,    0, 1, 3);
        set_row(4,  300, -512,    1,   -1,   38,  -64,    0,    0, 0, 3);
        set_row(5,   10,   20,  -30,   40,    1,    3,   -4,    5, 0, 2);
        set_row(6,   10,   20,  -30,   40,    3,    5,   -7,   10, 0, 1);
        set_row(7,   10,   20,  -30,   40,    5,   10,  -15,   20, 0, 0);
        set_row(8,   10,   20,  -30,   40,   10,   20,  -30,   40, 0, 0);
        set_row(9, -128, -127,  127,  128, -127, -127,  127,  127, 2, 1);

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b1;
        @(posedge iCLK);
        #1;
        check("rst_valid", int'(oVALID), 0);
        check("rst_data", int'($signed(oDATA)), 0);
        check("rst_eof", int'(oEOF), 0);
        check("rst_clip_cnt", int'(oCLIP_CNT), 0);
        check("rst_shift", int'(oSHIFT), SINIT);
        check("rst_ready", int'(oREADY), 1);

        // Back-to-back table frames: iVALID stays high across each boundary.
        for (int i = 0; i < 10; i++) begin
            cur = tbl[i];
            drive_frame(0, i > 0);
        end
        idle(6);

        // Clear after two accepted samples.
        send(20, 20, acc, w);
        send(-20, -20, acc, w);
        exp_q.delete();
        iCLR = 1'b1;
        @(posedge iCLK);
        #1;
        iCLR = 1'b0;
        check("clr_valid", int'(oVALID), 0);
        check("clr_eof", int'(oEOF), 0);
        check("clr_shift", int'(oSHIFT), SINIT);
        check("clr_clip_kept", int'(oCLIP_CNT), tbl[9].clip);
        check("clr_ready", int'(oREADY), 1);
        idle(4);

        m_shift = SINIT;
        model_frame(5, -7, 127, -127);
        drive_frame(0, 0);
        idle(6);

        // Random frames with varying amplitude so the shift walks up and down.
        for (int f = 0; f < 40; f++) begin
            mode = int'($urandom_range(0, 2));
            amp = (mode == 0) ? 512 : ((mode == 1) ? 150 : 20);
            for (int k = 0; k < N; k++) begin
                xs[k] = int'($urandom_range(0, 2 * amp - 1)) - amp;
            end
            model_frame(xs[0], xs[1], xs[2], xs[3]);
            drive_frame(2, 0);
        end
        idle(8);
        check("pending_outputs", exp_q.size(), 0);
        check("pending_eofs", eof_q.size(), 0);

        // Asynchronous reset in the middle of a frame.
        cur.din[0] = 300;
        send(300, 0, acc, w);
        send(-300, 0, acc, w);
        iRSTn = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", int'(oVALID), 0);
        check("mid_rst_data", int'($signed(oDATA)), 0);
        check("mid_rst_clip_cnt", int'(oCLIP_CNT), 0);
        check("mid_rst_shift", int'(oSHIFT), SINIT);
        check("mid_rst_eof", int'(oEOF), 0);
        @(negedge iCLK);
        iRSTn = 1'b1;
        @(posedge iCLK);
        #1;
        m_shift = SINIT;
        model_frame(300, -512, 10, -128);
        drive_frame(0, 0);
        idle(8);
        check("final_pending_outputs", exp_q.size(), 0);
        check("final_pending_eofs", eof_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clip_scale_ctrl.md
# clip_scale_ctrl

- Frame-adaptive scaling and saturation controller that sits between an FFT butterfly stage output and the next stage input.
- Each accepted sample is right-shifted with rounding by the current frame shift, then saturated symmetrically to OL bits.
- Clip events and headroom are counted per N-sample frame, and the shift for the next frame is adjusted at each frame boundary. Downstream sees a fixed-latency stream plus a per-frame end marker with that frame's clip count.

## Interface
- IL, 10, input word length (signed); IL > OL
- OL, 8, output word length (signed)
- N, 64, samples per frame; N ≥ 2
- SMAX, 3, maximum shift; 1 ≤ SMAX ≤ IL-1
- SINIT, 0, shift after reset/clear; SINIT ≤ SMAX
- CLIP_TH, 0, clip count above which shift increments
- iCLK  in  1  clock, rising edge
- iRSTn  in  1  asynchronous active-low reset
- iCLR  in  1  synchronous clear, highest priority after reset
- iVALID  in  1  input sample valid
- iDATA  in  IL  signed input sample
- oREADY  out  1  block accepts a sample this cycle
- oVALID  out  1  output sample valid
- oDATA  out  OL  signed scaled/clipped sample
- oEOF  out  1  one-cycle pulse: frame complete, oCLIP_CNT updated
- oCLIP_CNT  out  clog2(N+1)  clip count of last completed frame
- oSHIFT  out  clog2(SMAX+1)  shift applied to the frame in progress

## Operation
- Reset values:
  - oVALID=0, oDATA=0, oEOF=0, oCLIP_CNT=0, oSHIFT=SINIT.
  - State RUN, frame counter 0, statistics cleared.
- Accept: iVALID & oREADY. No downstream backpressure.
- oREADY = (state==RUN); decoded from the state register only.
- FSM states RUN, DRAIN1, DRAIN2, UPDATE:
  - RUN: accept samples. On accepting sample index N-1 → DRAIN1, and clear the frame counter.
  - DRAIN1 → DRAIN2 → UPDATE, unconditionally.
  - UPDATE: apply the shift rule, pulse oEOF, load oCLIP_CNT, clear statistics → RUN.
- Stage 1 (registered):
  - s=0: y = sign-extend(x) to IL+1 bits.
  - s>0: y = (x + 2^(s-1)) >>> s, computed in IL+1 bits so there is no wrap.
- Stage 2 (registered) saturation:
  - y > 2^(OL-1)-1 → 2^(OL-1)-1, clip.
  - y < -(2^(OL-1)-1) → -(2^(OL-1)-1), clip. -2^(OL-1) is never emitted and counts as a clip.
  - Otherwise pass y unchanged.
- Statistics, updated on each stage-2 valid:
  - clip_cnt += clip.
  - big |= (|y| ≥ 2^(OL-2)), evaluated before saturation.
- Shift rule in UPDATE, evaluated in this order:
  - clip_cnt > CLIP_TH and s < SMAX → s+1.
  - Else clip_cnt==0, big==0 and s > 0 → s-1.
  - Else hold.
  - s holds at SMAX and at 0.
- iCLR:
  - Next state RUN, frame counter 0, both pipeline valids 0, statistics cleared, oSHIFT=SINIT.
  - No oEOF pulse. oCLIP_CNT retains its value.
- Reset mid-frame: identical to iCLR, plus oCLIP_CNT=0 and oDATA=0.

## Timing
- Latency: sample accepted at edge E → oVALID/oDATA registered at edge E+2.
- oDATA holds its last value while oVALID=0.
- Last sample of a frame accepted at E0:
  - DRAIN1 from E0, DRAIN2 from E0+1.
  - Last output and final statistics at E0+2.
  - UPDATE from E0+2. At E0+3: oEOF=1 for one cycle, oCLIP_CNT and oSHIFT take new values, state RUN.
- oREADY is low for exactly 3 cycles per frame, so sustained throughput is N samples per N+3 cycles.
- Shift is constant across every sample of a frame. There is no mixed-shift frame.
- iVALID high while oREADY low: sample ignored, not queued.

## Structure
- Shared package fft_ctrl_pkg, reused by sibling stage controllers:
  - clog2 function.
  - FSM state encodings: RUN=2'd0, DRAIN1=2'd1, DRAIN2=2'd2, UPDATE=2'd3.
- One combinational sub-module, sat_clip (parameters W_IN, W_OUT):
  - Symmetric saturation with the clip flag and big flag outputs.
  - Instantiated in stage 2.
- Controller top: FSM, frame counter, shift register, rounding shifter, statistics.

## Test plan
All cases use IL=10, OL=8, N=4, SMAX=3, SINIT=0, CLIP_TH=0.
- Reset, no stimulus → oVALID=0, oDATA=0, oEOF=0, oCLIP_CNT=0, oSHIFT=0, oREADY=1 from the first edge after release.
- Shift 0, frame 5,-7,127,-127 → outputs 5,-7,127,-127 two cycles after each accept; oEOF with oCLIP_CNT=0; big=1, so oSHIFT stays 0.
- Shift 0, frame 300,-512,10,-128 → outputs 127,-127,10,-127; oCLIP_CNT=3; oSHIFT→1.
- Shift 1, frame 3,-3,300,-512 → outputs 2,-1,127,-127; oCLIP_CNT=2; oSHIFT→2.
- Shift 1, frame 10,20,-30,40 → outputs 5,10,-15,20; oCLIP_CNT=0; oSHIFT→0. Repeating the clip frame at SMAX leaves oSHIFT=3.
- Handshake and clear cases:
  - iVALID held high across a frame boundary → exactly 3 cycles with oREADY=0 and no samples accepted.
  - iCLR after 2 accepted samples → oVALID=0 next cycle, no oEOF, oSHIFT=0.
  - A following full frame produces a normal oEOF.
